matvec_accel_nxn: RTL and testbench
===================================

Name: matvec_accel_nxn

Overview:
- Parametrised N×N matrix × N-vector multiply accelerator. It is the next generation of the fixed 3×3 datapath in the neural-network accelerator.
- Operands are captured on a start strobe. The block then iterates over columns, with N parallel row MACs running one column per cycle.
- Results are post-processed with an optional ReLU and saturated to the output width. Completion is reported with a done pulse.
- It sits between the operand/weight buffers and the layer output register stage.

Parameters:
- N, 3, matrix dimension (rows = columns = vector length), N >= 2
- DW, 8, element width of A and x
- OUT_W, 16, width of each output element y[i]
- ACC_W, 2*DW+$clog2(N), internal accumulator width; derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement operands and outputs, 0 = unsigned; captured at start
- relu_en  in  1  1 = clamp negative results to 0 (signed mode only); captured at start
- a_flat  in  N*N*DW  row-major matrix; A[i][j] at bits [(i*N+j)*DW +: DW]
- x_flat  in  N*DW  vector; x[j] at bits [j*DW +: DW]
- y_flat  out  N*OUT_W  registered results; y[i] at bits [i*OUT_W +: OUT_W]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when y_flat updates
- sat_flag  out  N  per-row flag; 1 = last result was clamped

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, column counter = 0
  - accumulators, operand registers, y_flat, sat_flag, done and busy all = 0
  - Reset mid-operation discards the computation; y_flat returns to 0, not to the previous result.
- States: IDLE, COMPUTE, WRITE, DONE.
- IDLE: on an edge with start=1:
  - capture a_flat, x_flat, signed_mode, relu_en
  - clear the accumulators, set col = 0
  - go to COMPUTE
- COMPUTE: each edge, for every i, acc[i] += A[i][col]*x[col].
  - Product and extension are signed or unsigned per the captured mode, extended to ACC_W.
  - col increments each edge.
  - After the edge with col = N-1, go to WRITE. COMPUTE lasts exactly N cycles.
- WRITE: one edge. For each row:
  - If relu and signed mode are both set and acc < 0, the value becomes 0.
  - Saturate to OUT_W:
    - unsigned range is [0, 2^OUT_W-1]
    - signed range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - Set sat_flag[i] = 1 only if clamping occurred. ReLU zeroing does not set sat_flag.
  - Load y_flat and sat_flag, then go to DONE.
- DONE: done = 1 for this single cycle; next edge goes to IDLE.
- Latency: start sampled at edge E0; y_flat valid and done high in the cycle after edge E0+N+1.
- Throughput: one operation every N+3 cycles; a new start is accepted only once back in IDLE.
- start while busy is ignored: no capture, no state effect.
- y_flat and sat_flag hold their values until the next WRITE or reset.
- Input buses may change freely after the capture edge without affecting the result.
- relu_en with signed_mode = 0 has no effect.
- The accumulator never overflows internally, because ACC_W covers N worst-case products.

Decomposition:
- Shared package matvec_pkg holds:
  - state encoding localparams
  - the ACC_W derivation
  - saturation bound constants as functions of OUT_W
- Sub-module matvec_row_mac:
  - one DW×DW multiply-accumulate with sign-mode extension, accumulator clear and enable
  - instantiated N times via generate
- Saturation/ReLU stays inline in WRITE logic.

Test Plan:
- Identity case: N=3, unsigned, A=I, x=(5,7,9), start one cycle.
  - y = (5,7,9) and sat_flag = 0
  - done pulses exactly once, 5 cycles after the start edge
  - busy high for 5 cycles
- Unsigned saturation: all elements 255.
  - Accumulator 195075 > 65535, so y = (65535,65535,65535) and sat_flag = 3'b111.
- Signed with and without ReLU:
  - A row0 = (-1,0,0), other rows 0, x = (100,0,0); relu_en = 0 gives y0 = 16'hFF9C.
  - Repeating with relu_en = 1 gives y0 = 0 and sat_flag[0] = 0.
- Signed saturation: all A and x elements = -128.
  - Each row sums to 49152, so y = 32767 for every row and sat_flag = 3'b111.
- Start while busy: pulse start again during COMPUTE with different operands.
  - Result matches the first operands only; exactly one done pulse.
- Reset mid-COMPUTE, then N=4: drop reset_n at col = 1.
  - busy, done and y_flat go to 0 immediately.
  - Rerun with N=4 and A[i][j]=i+j, x=(1,1,1,1): y = (6,10,14,18), done 6 cycles after start.

Source files
------------

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared definitions for the NxN matrix-vector accelerator.
//   - FSM state encodings
//   - accumulator width derivation
//   - output saturation bounds, expressed in a 64-bit signed compare domain
package matvec_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_WRITE   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // N full-width products summed never exceed 2*DW + clog2(N) bits
   function automatic int acc_w(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic logic signed [63:0] sat_umax(input int out_w);
      return (64'sd1 <<< out_w) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_smax(input int out_w);
      return (64'sd1 <<< (out_w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_smin(input int out_w);
      return -(64'sd1 <<< (out_w - 1));
   endfunction

endpackage

// File: rtl/matvec_accel_nxn_row_mac.sv
// matvec_row_mac: one row's multiply-accumulate lane.
//   clk, reset_n    : clock, async active-low reset
//   clr             : synchronous accumulator clear (takes priority over en)
//   en              : add a*x into the accumulator this edge
//   signed_mode     : 1 = operands are two's complement, 0 = unsigned
//   a, x            : DW-bit operands
//   acc             : ACC_W-bit running sum
module matvec_row_mac #(
   parameter int DW    = 8,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic             signed_mode,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    x,
   output logic [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0] prod_s;
   logic        [2*DW-1:0] prod_u;
   logic        [ACC_W-1:0] prod_ext;

   // Operands are pre-extended to 2*DW so the product is exact in that width
   assign prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{x[DW-1]}}, x});
   assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, x};

   always_comb begin
      if (signed_mode) prod_ext = ACC_W'(prod_s);
      else             prod_ext = ACC_W'(prod_u);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  acc <= '0;
      else if (clr)  acc <= '0;
      else if (en)   acc <= acc + prod_ext;
   end

endmodule

// File: rtl/matvec_accel_nxn.sv
// matvec_accel_nxn: NxN matrix times N-vector, one column per cycle with
// N parallel row MACs, optional ReLU and saturation to OUT_W.
//   clk, reset_n  : clock, async active-low reset
//   start         : launch request, only honoured in IDLE
//   signed_mode   : two's complement operands/outputs when 1 (captured)
//   relu_en       : clamp negative results to 0 in signed mode (captured)
//   a_flat        : row-major matrix, A[i][j] at [(i*N+j)*DW +: DW]
//   x_flat        : vector, x[j] at [j*DW +: DW]
//   y_flat        : registered results, y[i] at [i*OUT_W +: OUT_W]
//   busy          : high outside IDLE
//   done          : one-cycle pulse in the cycle y_flat first shows a result
//   sat_flag      : per-row, result was clamped to the OUT_W range
module matvec_accel_nxn
   import matvec_pkg::*;
#(
   parameter int N     = 3,
   parameter int DW    = 8,
   parameter int OUT_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                signed_mode,
   input  logic                relu_en,
   input  logic [N*N*DW-1:0]   a_flat,
   input  logic [N*DW-1:0]     x_flat,
   output logic [N*OUT_W-1:0]  y_flat,
   output logic                busy,
   output logic                done,
   output logic [N-1:0]        sat_flag
);

   localparam int ACC_W = acc_w(N, DW);
   localparam int CW    = $clog2(N);
   localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

   localparam logic signed [63:0] U_MAX = sat_umax(OUT_W);
   localparam logic signed [63:0] S_MAX = sat_smax(OUT_W);
   localparam logic signed [63:0] S_MIN = sat_smin(OUT_W);

   logic [1:0]                    state;
   logic [CW-1:0]                 col;
   logic [N*N*DW-1:0]             a_q;
   logic [N*DW-1:0]               x_q;
   logic                          mode_q;
   logic                          relu_q;
   logic [N-1:0][ACC_W-1:0]       acc;
   logic [N-1:0][OUT_W-1:0]       y_q;
   logic [N-1:0][OUT_W-1:0]       y_nxt;
   logic [N-1:0]                  sat_q;
   logic [N-1:0]                  sat_nxt;
   logic [DW-1:0]                 x_col;
   logic                          take;
   logic                          mac_en;

   assign take   = (state == ST_IDLE) && start;
   assign mac_en = (state == ST_COMPUTE);
   assign busy   = (state != ST_IDLE);
   assign done   = (state == ST_DONE);
   assign y_flat   = y_q;
   assign sat_flag = sat_q;

   // Control and operand capture. Starts outside IDLE fall through untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         col    <= '0;
         a_q    <= '0;
         x_q    <= '0;
         mode_q <= 1'b0;
         relu_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_COMPUTE;
                  col    <= '0;
                  a_q    <= a_flat;
                  x_q    <= x_flat;
                  mode_q <= signed_mode;
                  relu_q <= relu_en;
               end
            end
            ST_COMPUTE: begin
               if (col == COL_LAST) begin
                  state <= ST_WRITE;
                  col   <= '0;
               end else begin
                  col <= col + CW'(1);
               end
            end
            ST_WRITE: state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign x_col = x_q[int'(col)*DW +: DW];

   for (genvar i = 0; i < N; i++) begin : g_row
      logic [DW-1:0]          a_col;
      logic signed [63:0]     v;
      logic [OUT_W-1:0]       y_row;
      logic                   sat_row;

      assign a_col = a_q[(i*N + int'(col))*DW +: DW];

      matvec_row_mac #(
         .DW    (DW),
         .ACC_W (ACC_W)
      ) u_mac (
         .clk         (clk),
         .reset_n     (reset_n),
         .clr         (take),
         .en          (mac_en),
         .signed_mode (mode_q),
         .a           (a_col),
         .x           (x_col),
         .acc         (acc[i])
      );

      // ReLU first, then clamp; ReLU zeroing alone never raises sat
      always_comb begin
         sat_row = 1'b0;
         if (mode_q) v = 64'($signed(acc[i]));
         else        v = 64'(acc[i]);
         if (mode_q && relu_q && (v < 64'sd0)) v = 64'sd0;
         if (mode_q) begin
            if (v > S_MAX) begin
               v = S_MAX;
               sat_row = 1'b1;
            end else if (v < S_MIN) begin
               v = S_MIN;
               sat_row = 1'b1;
            end
         end else if (v > U_MAX) begin
            v = U_MAX;
            sat_row = 1'b1;
         end
         y_row = v[OUT_W-1:0];
      end

      assign y_nxt[i]   = y_row;
      assign sat_nxt[i] = sat_row;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y_q   <= '0;
         sat_q <= '0;
      end else if (state == ST_WRITE) begin
         y_q   <= y_nxt;
         sat_q <= sat_nxt;
      end
   end

endmodule

// File: tb/tb_matvec_accel_nxn.sv
// Bench for matvec_accel_nxn: an N=3 and an N=4 instance on a shared clock
// and reset. Expected results come from a behavioural model and travel
// through a scoreboard queue until the matching done pulse.
module tb_matvec_accel_nxn;

   logic         clk = 1'b0;
   logic         reset_n;

   logic         start3, sm3, relu3;
   logic [71:0]  a3;
   logic [23:0]  x3;
   logic [47:0]  y3;
   logic         busy3, done3;
   logic [2:0]   sat3;

   logic         start4, sm4, relu4;
   logic [127:0] a4;
   logic [31:0]  x4;
   logic [63:0]  y4;
   logic         busy4, done4;
   logic [3:0]   sat4;

   typedef struct {
      logic [63:0] y;
      logic [3:0]  sat;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   errors  = 0;
   int   ma[16];
   int   mx[4];

   always #5 clk = ~clk;

   matvec_accel_nxn #(.N(3), .DW(8), .OUT_W(16)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start3), .signed_mode(sm3),
      .relu_en(relu3), .a_flat(a3), .x_flat(x3), .y_flat(y3),
      .busy(busy3), .done(done3), .sat_flag(sat3)
   );

   matvec_accel_nxn #(.N(4), .DW(8), .OUT_W(16)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .signed_mode(sm4),
      .relu_en(relu4), .a_flat(a4), .x_flat(x4), .y_flat(y4),
      .busy(busy4), .done(done4), .sat_flag(sat4)
   );

   // Behavioural reference: straight sum, ReLU, clamp to 16 bits
   function automatic exp_t model(input int n, input bit sm, input bit relu);
      exp_t e;
      logic [7:0] ab, xb;
      longint acc, av, xv;
      e.y = '0;
      e.sat = '0;
      for (int i = 0; i < n; i++) begin
         acc = 0;
         for (int j = 0; j < n; j++) begin
            ab = ma[i*n+j][7:0];
            xb = mx[j][7:0];
            av = sm ? longint'($signed(ab)) : longint'(ab);
            xv = sm ? longint'($signed(xb)) : longint'(xb);
            acc += av * xv;
         end
         if (sm && relu && acc < 0) acc = 0;
         if (sm) begin
            if (acc > 32767)       begin acc = 32767;  e.sat[i] = 1'b1; end
            else if (acc < -32768) begin acc = -32768; e.sat[i] = 1'b1; end
         end else if (acc > 65535) begin
            acc = 65535;
            e.sat[i] = 1'b1;
         end
         e.y[i*16 +: 16] = acc[15:0];
      end
      return e;
   endfunction

   task automatic drive_ops(input int n, input bit sm, input bit relu);
      logic [127:0] ab;
      logic [31:0]  xb;
      ab = '0;
      xb = '0;
      for (int k = 0; k < n*n; k++) ab[k*8 +: 8] = ma[k][7:0];
      for (int k = 0; k < n; k++)   xb[k*8 +: 8] = mx[k][7:0];
      if (n == 3) begin
         a3 = ab[71:0]; x3 = xb[23:0]; sm3 = sm; relu3 = relu;
      end else begin
         a4 = ab; x4 = xb; sm4 = sm; relu4 = relu;
      end
   endtask

   // Launch one op from ma/mx, watch N+6 cycles, check against the scoreboard.
   // inject: re-pulse start with junk operands two cycles into COMPUTE.
   task automatic run_op(input string name, input int n, input bit sm,
                         input bit relu, input bit inject);
      exp_t e;
      int dcnt = 0, bcnt = 0, dcyc = -1;
      logic [63:0] ycap = '0, ycur;
      logic [3:0]  scap = '0;
      logic        d, b;
      drive_ops(n, sm, relu);
      sbq.push_back(model(n, sm, relu));
      if (n == 3) start3 = 1'b1; else start4 = 1'b1;
      for (int c = 1; c <= n + 6; c++) begin
         @(negedge clk);
         d    = (n == 3) ? done3 : done4;
         b    = (n == 3) ? busy3 : busy4;
         ycur = (n == 3) ? {16'h0, y3} : y4;
         if (b) bcnt++;
         if (d) begin
            dcnt++;
            dcyc = c;
            ycap = ycur;
            scap = (n == 3) ? {1'b0, sat3} : sat4;
         end
         start3 = 1'b0;
         start4 = 1'b0;
         if (inject && c == 2) begin
            for (int k = 0; k < 16; k++) ma[k] = 17 + k;
            for (int k = 0; k < 4; k++)  mx[k] = 3;
            drive_ops(n, ~sm, 1'b0);
            if (n == 3) start3 = 1'b1; else start4 = 1'b1;
         end
      end
      e = sbq.pop_front();
      vectors++;
      if (dcnt !== 1) begin
         errors++;
         $display("FAIL %s done_count: got %0d want 1", name, dcnt);
      end
      vectors++;
      if (dcyc !== n + 2) begin
         errors++;
         $display("FAIL %s done_latency: got %0d want %0d", name, dcyc, n + 2);
      end
      vectors++;
      if (bcnt !== n + 2) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, n + 2);
      end
      vectors++;
      if (ycap !== e.y) begin
         errors++;
         $display("FAIL %s y: got %h want %h", name, ycap, e.y);
      end
      vectors++;
      if (scap !== e.sat) begin
         errors++;
         $display("FAIL %s sat_flag: got %b want %b", name, scap, e.sat);
      end
      vectors++;
      ycur = (n == 3) ? {16'h0, y3} : y4;
      if (ycur !== e.y) begin
         errors++;
         $display("FAIL %s y_hold: got %h want %h", name, ycur, e.y);
      end
   endtask

   task automatic set_all(input int av, input int xv);
      for (int k = 0; k < 16; k++) ma[k] = av;
      for (int k = 0; k < 4; k++)  mx[k] = xv;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start3 = 1'b0; start4 = 1'b0;
      sm3 = 1'b0; sm4 = 1'b0; relu3 = 1'b0; relu4 = 1'b0;
      a3 = '1; a4 = '1; x3 = '1; x4 = '1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy3, done3, sat3, y3} !== '0) begin
         errors++;
         $display("FAIL reset3: got %b/%b/%b/%h want 0", busy3, done3, sat3, y3);
      end
      vectors++;
      if ({busy4, done4, sat4, y4} !== '0) begin
         errors++;
         $display("FAIL reset4: got %b/%b/%b/%h want 0", busy4, done4, sat4, y4);
      end
   endtask

   task automatic test_identity();
      set_all(0, 0);
      ma[0] = 1; ma[4] = 1; ma[8] = 1;
      mx[0] = 5; mx[1] = 7; mx[2] = 9;
      run_op("identity", 3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_unsigned_sat();
      set_all(255, 255);
      run_op("unsigned_sat", 3, 1'b0, 1'b0, 1'b0);
      set_all(255, 255);
      run_op("unsigned_relu_ignored", 3, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_signed_relu();
      set_all(0, 0);
      ma[0] = -1; mx[0] = 100;
      run_op("signed_norelu", 3, 1'b1, 1'b0, 1'b0);
      set_all(0, 0);
      ma[0] = -1; mx[0] = 100;
      run_op("signed_relu", 3, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_signed_sat();
      set_all(-128, -128);
      run_op("signed_sat", 3, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) ma[k] = (k % 2 == 0) ? 127 : -128;
      for (int k = 0; k < 3; k++) mx[k] = -128 + k * 90;
      run_op("signed_mixed", 3, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_start_while_busy();
      for (int k = 0; k < 9; k++) ma[k] = k + 1;
      mx[0] = 2; mx[1] = 3; mx[2] = 4;
      run_op("start_while_busy", 3, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_op();
      set_all(9, 9);
      drive_ops(3, 1'b0, 1'b0);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({busy3, done3, sat3, y3} !== '0) begin
         errors++;
         $display("FAIL reset_mid_op: got %b/%b/%b/%h want 0", busy3, done3, sat3, y3);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_op_idle: got busy %b want 0", busy3);
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) ma[i*4+j] = i + j;
      for (int k = 0; k < 4; k++) mx[k] = 1;
      run_op("n4_ramp", 4, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_unsigned_sat();
      test_signed_relu();
      test_signed_sat();
      test_start_while_busy();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
